// File: rtl/ifetch_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// ifetch_stage_if : instruction-memory req/ack bus between fetch and memory
// Revision 1.0
// ---------------------------------------------------------------------------
interface ifetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// ifetch_stage : riscv32i fetch stage - PC, imem handshake, IF/ID + skid
// Revision 1.0
// ---------------------------------------------------------------------------
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  ifetch_stage_if.master   imem,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [6:0]       id_op,
  input  wire logic        id_stall,
  input  wire logic        id_suspend,
  input  wire logic        resume,
  input  wire logic        ex_branch,
  input  wire logic        ex_jal,
  input  wire logic        ex_jalr,
  input  wire logic [2:0]  ex_funct3,
  input  wire logic [31:0] ex_pc,
  input  wire logic [31:0] ex_imm,
  input  wire logic [31:0] ex_jalr_tgt,
  input  wire logic        gt,
  input  wire logic        lt,
  input  wire logic        eq,
  output logic             misalign_err
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_SKID    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        halt_pend_q, halt_pend_d;
  logic        misalign_q, misalign_d;

  logic        cond;
  logic        taken;
  logic        suspend;
  logic        ack_v;
  logic [31:0] tgt_raw;
  logic [31:0] tgt_fetch;
  logic        unused_sig;

  // gt is not needed by any condition code; bit0 of the JALR target is always cleared
  assign unused_sig = ^{gt, ex_jalr_tgt[0], tgt_raw[0]};

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:          cond = eq;
      3'b001:          cond = ~eq;
      3'b100, 3'b110:  cond = lt;
      3'b101, 3'b111:  cond = ~lt;
      default:         cond = 1'b0;
    endcase
  end

  assign tgt_raw   = ex_jalr ? {ex_jalr_tgt[31:1], 1'b0} : (ex_pc + ex_imm);
  assign tgt_fetch = {tgt_raw[31:2], 2'b00};
  assign taken     = (state_q != S_HALT) & (ex_jal | ex_jalr | (ex_branch & cond));
  assign suspend   = id_valid_q & id_suspend & ~id_stall & ~taken;
  // an ack with no request outstanding (e.g. straight after reset) is stale
  assign ack_v     = imem.imem_ack & req_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    halt_pend_d  = halt_pend_q;
    misalign_d   = misalign_q;

    if (taken) begin
      misalign_d  = misalign_q | tgt_raw[1];
      id_valid_d  = 1'b0;
      pc_d        = tgt_fetch;
      halt_pend_d = 1'b0;
      if (req_q && !imem.imem_ack) begin
        state_d = S_DISCARD;
      end else begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = tgt_fetch;
      end
    end else if (suspend) begin
      pc_d       = id_pc_q + 32'd4;
      id_valid_d = 1'b0;
      if (req_q && !imem.imem_ack) begin
        state_d     = S_DISCARD;
        halt_pend_d = 1'b1;
      end else begin
        state_d = S_HALT;
        req_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (id_valid_q && !id_stall) id_valid_d = 1'b0;
          req_d  = 1'b1;
          addr_d = pc_q;
          if (ack_v) begin
            pc_d   = pc_q + 32'd4;
            addr_d = pc_q + 32'd4;
            if (!id_valid_q || !id_stall) begin
              id_valid_d = 1'b1;
              id_instr_d = imem.imem_rdata;
              id_pc_d    = pc_q;
            end else begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = S_SKID;
              req_d        = 1'b0;
            end
          end
        end
        S_SKID: begin
          req_d = 1'b0;
          if (!id_stall) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q;
            state_d    = S_REQ;
            req_d      = 1'b1;
            addr_d     = pc_q;
          end
        end
        S_DISCARD: begin
          if (ack_v) begin
            if (halt_pend_q) begin
              state_d     = S_HALT;
              req_d       = 1'b0;
              halt_pend_d = 1'b0;
            end else begin
              state_d = S_REQ;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end
          end
        end
        default: begin
          id_valid_d = 1'b0;
          req_d      = 1'b0;
          if (resume) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc_q      <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      halt_pend_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      halt_pend_q  <= halt_pend_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_op          = id_instr_q[6:0];
  assign misalign_err   = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ifetch_stage : directed bench with a queue-based fetch model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ifetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid, misalign_err;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_op;
  logic        id_stall = 0, id_suspend = 0, resume = 0;
  logic        ex_branch = 0, ex_jal = 0, ex_jalr = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [31:0] ex_pc = 0, ex_imm = 0, ex_jalr_tgt = 0;
  logic        gt = 0, lt = 0, eq = 0;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  ifetch_stage_if imem_if ();

  ifetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem(imem_if),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_op(id_op),
    .id_stall(id_stall), .id_suspend(id_suspend), .resume(resume),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_jalr_tgt(ex_jalr_tgt), .gt(gt), .lt(lt), .eq(eq),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: IF/ID + skid as a 2-deep queue; a request is open whenever the queue has room
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  logic        m_req, m_flush, m_halted, m_halt_after, m_mis;
  logic [31:0] m_pc, m_addr;

  function automatic logic br_cond(input logic [2:0] f3, input logic e, input logic l);
    case (f3)
      3'b000: return e;
      3'b001: return !e;
      3'b100, 3'b110: return l;
      3'b101, 3'b111: return !l;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        ack, tk, sus;
    logic [31:0] tgt;
    ncyc++;
    if (reset) begin
      q_instr.delete(); q_pc.delete();
      m_req = 0; m_flush = 0; m_halted = 0; m_halt_after = 0; m_mis = 0;
      m_pc = RST_PC; m_addr = RST_PC;
    end else begin
      ack = imem_if.imem_ack && m_req;
      tk  = !m_halted && (ex_jal || ex_jalr || (ex_branch && br_cond(ex_funct3, eq, lt)));
      tgt = ex_jalr ? (ex_jalr_tgt & ~32'd1) : ex_pc + ex_imm;
      sus = (q_pc.size() > 0) && id_suspend && !id_stall && !tk;
      if (tk) begin
        if (tgt[1]) m_mis = 1;
        q_instr.delete(); q_pc.delete();
        m_pc = tgt & ~32'd3;
        m_halt_after = 0;
        if (m_req && !imem_if.imem_ack) m_flush = 1;
        else begin m_flush = 0; m_req = 1; m_addr = m_pc; end
      end else if (sus) begin
        m_pc = q_pc[0] + 32'd4;
        q_instr.delete(); q_pc.delete();
        if (m_req && !imem_if.imem_ack) begin m_flush = 1; m_halt_after = 1; end
        else begin m_halted = 1; m_req = 0; end
      end else if (m_halted) begin
        if (resume) begin m_halted = 0; m_req = 1; m_addr = m_pc; end
      end else if (m_flush) begin
        if (ack) begin
          m_flush = 0;
          if (m_halt_after) begin m_halted = 1; m_req = 0; m_halt_after = 0; end
          else begin m_req = 1; m_addr = m_pc; end
        end
      end else begin
        if (q_pc.size() > 0 && !id_stall) begin
          void'(q_instr.pop_front()); void'(q_pc.pop_front());
        end
        if (ack) begin
          q_instr.push_back(imem_if.imem_rdata);
          q_pc.push_back(m_addr);
          m_pc = m_addr + 32'd4;
        end
        m_req  = (q_pc.size() < 2);
        m_addr = m_pc;
      end
    end
  end

  // Compare process: DUT vs model every cycle
  always @(negedge clk) begin
    if (ncyc >= 1) begin
      chk("m_imem_req", {31'd0, imem_if.imem_req}, {31'd0, m_req});
      if (m_req) chk("m_imem_addr", imem_if.imem_addr, m_addr);
      chk("m_id_valid", {31'd0, id_valid}, {31'd0, q_pc.size() > 0});
      if (q_pc.size() > 0) begin
        chk("m_id_instr", id_instr, q_instr[0]);
        chk("m_id_pc", id_pc, q_pc[0]);
        chk("m_id_op", {25'd0, id_op}, {25'd0, q_instr[0][6:0]});
      end
      chk("m_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    imem_if.imem_ack = 0;
    imem_if.imem_rdata = 0;

    // reset and three back-to-back fetches
    repeat (3) step();
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rst_addr", imem_if.imem_addr, 32'h100);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    reset = 0;
    step();
    chk("first_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("first_addr", imem_if.imem_addr, 32'h100);
    imem_if.imem_ack = 1; imem_if.imem_rdata = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_addr", imem_if.imem_addr, 32'h104 + 32'(4 * i));
      chk("seq_id_pc", id_pc, 32'h100 + 32'(4 * i));
      chk("seq_op", {25'd0, id_op}, 32'h13);
    end

    // stall: word lands in skid, fetch pauses
    id_stall = 1; imem_if.imem_rdata = 32'hAAAA_0013;
    step();
    imem_if.imem_ack = 0;
    chk("skid_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("skid_hold_pc", id_pc, 32'h108);
    repeat (3) step();
    chk("skid_req2", {31'd0, imem_if.imem_req}, 32'd0);
    id_stall = 0;
    step();
    chk("skid_instr", id_instr, 32'hAAAA_0013);
    chk("skid_id_pc", id_pc, 32'h10C);
    chk("skid_resume_addr", imem_if.imem_addr, 32'h110);

    // BNE taken with a fetch outstanding
    ex_branch = 1; ex_funct3 = 3'b001; eq = 0; ex_pc = 32'h200; ex_imm = 32'hFFFF_FFF0;
    step();
    ex_branch = 0;
    chk("bne_valid", {31'd0, id_valid}, 32'd0);
    chk("bne_addr_hold", imem_if.imem_addr, 32'h110);
    step();
    chk("bne_addr_hold2", imem_if.imem_addr, 32'h110);
    imem_if.imem_ack = 1; imem_if.imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("bne_target", imem_if.imem_addr, 32'h1F0);
    chk("bne_dropped", {31'd0, id_valid}, 32'd0);
    imem_if.imem_rdata = 32'h0000_0013;
    step();
    chk("bne_fetch_pc", id_pc, 32'h1F0);

    // JALR to a misaligned target, with an ack in the same cycle
    ex_jalr = 1; ex_jalr_tgt = 32'h303; imem_if.imem_rdata = 32'h0BAD_0013;
    step();
    ex_jalr = 0; imem_if.imem_ack = 0;
    chk("jalr_addr", imem_if.imem_addr, 32'h300);
    chk("jalr_mis", {31'd0, misalign_err}, 32'd1);
    chk("jalr_drop", {31'd0, id_valid}, 32'd0);
    ex_branch = 1; ex_funct3 = 3'b111; lt = 1;
    step();
    ex_branch = 0; lt = 0;
    chk("bgeu_not_taken", imem_if.imem_addr, 32'h300);

    // jump to 0x40, fetch an ecall, suspend
    ex_jal = 1; ex_pc = 32'h0; ex_imm = 32'h40; imem_if.imem_ack = 1;
    step();
    ex_jal = 0;
    imem_if.imem_rdata = 32'h0000_0073;
    step();
    imem_if.imem_ack = 0;
    chk("ecall_pc", id_pc, 32'h40);
    id_suspend = 1;
    step();
    id_suspend = 0;
    chk("sus_discard_req", {31'd0, imem_if.imem_req}, 32'd1);
    imem_if.imem_ack = 1;
    step();
    chk("halt_req", {31'd0, imem_if.imem_req}, 32'd0);
    ex_jal = 1; ex_imm = 32'h500;
    step();
    ex_jal = 0; imem_if.imem_ack = 0;
    repeat (4) step();
    chk("halt_req_hold", {31'd0, imem_if.imem_req}, 32'd0);
    chk("halt_valid", {31'd0, id_valid}, 32'd0);
    resume = 1;
    step();
    resume = 0;
    chk("resume_addr", imem_if.imem_addr, 32'h44);

    // redirect beats suspend
    imem_if.imem_ack = 1;
    step();
    imem_if.imem_ack = 0;
    id_suspend = 1; ex_jal = 1; ex_pc = 32'h80; ex_imm = 32'h10;
    step();
    id_suspend = 0; ex_jal = 0;
    chk("rs_addr_hold", imem_if.imem_addr, 32'h48);
    imem_if.imem_ack = 1;
    step();
    imem_if.imem_ack = 0;
    chk("rs_no_halt", {31'd0, imem_if.imem_req}, 32'd1);
    chk("rs_target", imem_if.imem_addr, 32'h90);

    // reset mid-request, then a stale ack
    reset = 1;
    step();
    chk("mid_rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("mid_rst_addr", imem_if.imem_addr, 32'h100);
    chk("mid_rst_mis", {31'd0, misalign_err}, 32'd0);
    reset = 0; imem_if.imem_ack = 1; imem_if.imem_rdata = 32'h0000_0013;
    step();
    imem_if.imem_ack = 0;
    chk("stale_ack_valid", {31'd0, id_valid}, 32'd0);
    chk("stale_ack_addr", imem_if.imem_addr, 32'h100);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
